// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
package pipe_hazard_ctrl_pkg;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    FREEZE   = 2'd2
  } state_t;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_write;
  } ctrl_t;
endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// Saturating up-counter with async active-high reset.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                  cnt <= '0;
    else if (en && cnt != '1) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer: freeze > branch flush > load-use stall > fetch wait > normal.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int LU_STALL_CYCLES = 1,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  idex_memread,
  input  logic [REG_ADDR_W-1:0] idex_rd,
  input  logic                  branch_taken,
  input  logic                  imem_ready,
  input  logic                  dmem_ready,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_write,
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt
);
  localparam logic [1:0] LU_INIT = (LU_STALL_CYCLES > 1) ? 2'(LU_STALL_CYCLES - 2) : 2'd0;

  state_t     state, state_nxt, resume, resume_nxt, eff;
  logic [1:0] lu_cnt, lu_nxt;
  logic       hz, stall_inc, flush_inc;
  ctrl_t      ctrl;

  assign hz = idex_memread && (idex_rd != X0) &&
              ((idex_rd == id_rs1) || (idex_rd == id_rs2));

  // Leaving FREEZE evaluates the cycle as the stored state, so no cycle is lost.
  assign eff = (state == FREEZE) ? resume : state;

  always_comb begin
    ctrl       = '0;
    state_nxt  = eff;
    resume_nxt = resume;
    lu_nxt     = lu_cnt;
    stall_inc  = 1'b0;
    flush_inc  = 1'b0;
    if (!dmem_ready) begin
      state_nxt  = FREEZE;
      resume_nxt = eff;
    end else if (branch_taken) begin
      ctrl      = '{pc_write: 1'b1, ifid_write: 1'b0, ifid_flush: 1'b1,
                    idex_flush: 1'b1, exmem_write: 1'b1};
      state_nxt = RUN;
      lu_nxt    = 2'd0;
      flush_inc = 1'b1;
    end else if ((eff == RUN && hz) || eff == LU_STALL) begin
      ctrl      = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0,
                    idex_flush: 1'b1, exmem_write: 1'b1};
      stall_inc = 1'b1;
      if (eff == RUN) begin
        if (LU_STALL_CYCLES > 1) begin
          state_nxt = LU_STALL;
          lu_nxt    = LU_INIT;
        end
      end else if (lu_cnt == 2'd0) begin
        state_nxt = RUN;
      end else begin
        lu_nxt = lu_cnt - 2'd1;
      end
    end else if (!imem_ready) begin
      ctrl      = '{pc_write: 1'b0, ifid_write: 1'b1, ifid_flush: 1'b1,
                    idex_flush: 1'b0, exmem_write: 1'b1};
      stall_inc = 1'b1;
    end else begin
      ctrl = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0,
               idex_flush: 1'b0, exmem_write: 1'b1};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= RUN;
      resume <= RUN;
      lu_cnt <= 2'd0;
    end else begin
      state  <= state_nxt;
      resume <= resume_nxt;
      lu_cnt <= lu_nxt;
    end
  end

  assign pc_write    = !rst && ctrl.pc_write;
  assign ifid_write  = !rst && ctrl.ifid_write;
  assign ifid_flush  = !rst && ctrl.ifid_flush;
  assign idex_flush  = !rst && ctrl.idex_flush;
  assign exmem_write = !rst && ctrl.exmem_write;

  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .en(stall_inc), .cnt(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .en(flush_inc), .cnt(flush_cnt));
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: three controllers (1-, 2-, 3-cycle load-use; last with 2-bit counters) on shared inputs.
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  logic       clk = 1'b0, rst = 1'b1;
  logic [4:0] id_rs1 = 5'd1, id_rs2 = 5'd2, idex_rd = 5'd0;
  logic       idex_memread = 1'b0, branch_taken = 1'b0, imem_ready = 1'b1, dmem_ready = 1'b1;

  logic [4:0]  c1, c2, c3;
  logic [15:0] s1, f1, s2, f2;
  logic [1:0]  s3, f3;

  int checks = 0, failures = 0;

  localparam logic [4:0] NORM = 5'b11001, STL = 5'b00011, BR = 5'b10111,
                         FW = 5'b01101, FRZ = 5'b00000;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.LU_STALL_CYCLES(1), .CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .idex_memread(idex_memread),
    .idex_rd(idex_rd), .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_write(c1[4]), .ifid_write(c1[3]), .ifid_flush(c1[2]), .idex_flush(c1[1]), .exmem_write(c1[0]),
    .stall_cnt(s1), .flush_cnt(f1));
  pipe_hazard_ctrl #(.LU_STALL_CYCLES(2), .CNT_W(16)) d2 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .idex_memread(idex_memread),
    .idex_rd(idex_rd), .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_write(c2[4]), .ifid_write(c2[3]), .ifid_flush(c2[2]), .idex_flush(c2[1]), .exmem_write(c2[0]),
    .stall_cnt(s2), .flush_cnt(f2));
  pipe_hazard_ctrl #(.LU_STALL_CYCLES(3), .CNT_W(2)) d3 (
    .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .idex_memread(idex_memread),
    .idex_rd(idex_rd), .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
    .pc_write(c3[4]), .ifid_write(c3[3]), .ifid_flush(c3[2]), .idex_flush(c3[1]), .exmem_write(c3[0]),
    .stall_cnt(s3), .flush_cnt(f3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after the falling edge; checks follow 2 time units later.
  task automatic step(input logic mr, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                      input logic br, input logic im, input logic dm);
    @(negedge clk);
    idex_memread = mr; idex_rd = rd; id_rs1 = r1; id_rs2 = r2;
    branch_taken = br; imem_ready = im; dmem_ready = dm;
    #2;
  endtask

  task automatic idle();
    step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic hazard();
    step(1'b1, 5'd5, 5'd1, 5'd5, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic ctl3(input string tag, input logic [4:0] e1, input logic [4:0] e2, input logic [4:0] e3);
    chk({tag, "_d1"}, 32'(c1), 32'(e1));
    chk({tag, "_d2"}, 32'(c2), 32'(e2));
    chk({tag, "_d3"}, 32'(c3), 32'(e3));
  endtask

  task automatic cnt3(input string tag, input int e1, input int e2, input int e3, input bit stall);
    chk({tag, "_d1"}, stall ? 32'(s1) : 32'(f1), 32'(e1));
    chk({tag, "_d2"}, stall ? 32'(s2) : 32'(f2), 32'(e2));
    chk({tag, "_d3"}, stall ? 32'(s3) : 32'(f3), 32'(e3));
  endtask

  initial begin
    #1;
    ctl3("reset_ctrl", FRZ, FRZ, FRZ);
    cnt3("reset_stall", 0, 0, 0, 1'b1);
    cnt3("reset_flush", 0, 0, 0, 1'b0);
    @(negedge clk); rst = 1'b0;

    // Load-use hazard for one cycle, then idle
    hazard();  ctl3("lu_c0", STL, STL, STL);
    idle();    ctl3("lu_c1", NORM, STL, STL);
    cnt3("lu_stall_c1", 1, 1, 1, 1'b1);
    idle();    ctl3("lu_c2", NORM, NORM, STL);
    idle();    ctl3("lu_c3", NORM, NORM, NORM);
    cnt3("lu_stall_done", 1, 2, 3, 1'b1);

    // x0 destination never stalls
    step(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1); ctl3("x0_nohz", NORM, NORM, NORM);

    // Branch in the first cycle of a load-use stall wins and returns to RUN
    step(1'b1, 5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1); ctl3("br_over_lu", BR, BR, BR);
    idle();    ctl3("br_after", NORM, NORM, NORM);
    cnt3("br_flush", 1, 1, 1, 1'b0);
    cnt3("br_stall_kept", 1, 2, 3, 1'b1);

    // Freeze for 4 cycles inside a load-use stall (d3 has lu_cnt=1)
    hazard();  ctl3("fz_entry", STL, STL, STL);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b1, 1'b0);
      ctl3($sformatf("fz_hold%0d", i), FRZ, FRZ, FRZ);
      cnt3($sformatf("fz_cnt%0d", i), 2, 3, 3, 1'b1);
    end
    idle();    ctl3("fz_res0", NORM, STL, STL);
    idle();    ctl3("fz_res1", NORM, NORM, STL);
    idle();    ctl3("fz_res2", NORM, NORM, NORM);
    cnt3("fz_stall", 2, 4, 3, 1'b1);

    // Fetch wait for 3 cycles
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 5'd0, 5'd1, 5'd2, 1'b0, 1'b0, 1'b1);
      ctl3($sformatf("fw%0d", i), FW, FW, FW);
    end
    idle();    ctl3("fw_done", NORM, NORM, NORM);
    cnt3("fw_stall", 5, 7, 3, 1'b1);

    // Five branches: the 2-bit flush counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1);
      ctl3($sformatf("br%0d", i), BR, BR, BR);
    end
    idle();    cnt3("br_sat", 6, 6, 3, 1'b0);

    // Freeze outranks a branch and blocks the flush count
    step(1'b0, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0); ctl3("fz_over_br", FRZ, FRZ, FRZ);
    idle();    ctl3("fz_over_br_after", NORM, NORM, NORM);
    cnt3("fz_over_br_flush", 6, 6, 3, 1'b0);

    // Asynchronous reset mid-stall, between clock edges
    hazard();
    @(negedge clk);
    idex_memread = 1'b0; idex_rd = 5'd0; id_rs2 = 5'd2;
    #2 rst = 1'b1;
    #1;
    ctl3("arst_ctrl", FRZ, FRZ, FRZ);
    cnt3("arst_stall", 0, 0, 0, 1'b1);
    cnt3("arst_flush", 0, 0, 0, 1'b0);
    chk("arst_state", 32'(d3.state), 32'(RUN));
    @(negedge clk); rst = 1'b0;
    #2;
    ctl3("arst_after", NORM, NORM, NORM);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
